// File: rtl/axil_csr_regfile.sv
// AXI4-Lite slave register file: NUM_REGS read/write words with per-register write pulses.
// Define AXIL_CSR_STRB_EN to add the wstrb port and byte-masked writes; otherwise writes are full-word.
module axil_csr_regfile #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           wvalid,
  output logic                           wready,
  input  logic [DATA_WIDTH-1:0]          wdata,
`ifdef AXIL_CSR_STRB_EN
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
`endif
  output logic                           bvalid,
  input  logic                           bready,
  output logic [1:0]                     bresp,
  input  logic                           arvalid,
  output logic                           arready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int ADDR_LSB = $clog2(DATA_WIDTH/8);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam int SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int STRB_W   = DATA_WIDTH/8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_state_n;
  r_state_t r_state, r_state_n;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [STRB_W-1:0]     strb_in;

  logic                  aw_held, aw_held_n, w_held, w_held_n;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_n;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_n;
  logic [STRB_W-1:0]     w_strb_q, w_strb_n;
  logic                  awready_n, wready_n, bvalid_n;
  logic [1:0]            bresp_n;
  logic [NUM_REGS-1:0]   pulse_n;
  logic                  wr_en, wr_ok;
  logic [SEL_W-1:0]      wr_sel;

  logic                  arready_n, rvalid_n, rd_ok;
  logic [SEL_W-1:0]      rd_sel;
  logic [DATA_WIDTH-1:0] rdata_n;
  logic [1:0]            rresp_n;

`ifdef AXIL_CSR_STRB_EN
  assign strb_in = wstrb;
`else
  assign strb_in = '1;
`endif

  // Handshake rule on every channel: a beat transfers on a rising edge where valid && ready;
  // the source holds valid and payload steady until then, and every ready/valid here is registered.
  always_comb begin
    w_state_n = w_state;
    aw_held_n = aw_held;
    w_held_n  = w_held;
    aw_addr_n = aw_addr_q;
    w_data_n  = w_data_q;
    w_strb_n  = w_strb_q;
    awready_n = awready;
    wready_n  = wready;
    bvalid_n  = bvalid;
    bresp_n   = bresp;
    pulse_n   = '0;
    wr_en     = 1'b0;
    wr_ok     = aw_addr_n[ADDR_WIDTH-1:ADDR_LSB] < IDX_W'(NUM_REGS);
    wr_sel    = aw_addr_n[ADDR_LSB +: SEL_W];
    case (w_state)
      W_IDLE: begin
        if (awvalid && awready) begin
          aw_held_n = 1'b1;
          aw_addr_n = awaddr;
        end
        if (wvalid && wready) begin
          w_held_n = 1'b1;
          w_data_n = wdata;
          w_strb_n = strb_in;
        end
        wr_ok  = aw_addr_n[ADDR_WIDTH-1:ADDR_LSB] < IDX_W'(NUM_REGS);
        wr_sel = aw_addr_n[ADDR_LSB +: SEL_W];
        if (aw_held_n && w_held_n) begin
          wr_en     = wr_ok;
          if (wr_ok) pulse_n[wr_sel] = 1'b1;
          bvalid_n  = 1'b1;
          bresp_n   = wr_ok ? RESP_OKAY : RESP_SLVERR;
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
          awready_n = 1'b0;
          wready_n  = 1'b0;
          w_state_n = W_RESP;
        end else begin
          awready_n = !aw_held_n;
          wready_n  = !w_held_n;
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_n  = 1'b0;
          awready_n = 1'b1;
          wready_n  = 1'b1;
          w_state_n = W_IDLE;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  // rdata is taken from the registers before this edge's write, so a colliding read sees the old value.
  always_comb begin
    r_state_n = r_state;
    arready_n = arready;
    rvalid_n  = rvalid;
    rdata_n   = rdata;
    rresp_n   = rresp;
    rd_ok     = araddr[ADDR_WIDTH-1:ADDR_LSB] < IDX_W'(NUM_REGS);
    rd_sel    = araddr[ADDR_LSB +: SEL_W];
    case (r_state)
      R_IDLE: begin
        if (arvalid && arready) begin
          arready_n = 1'b0;
          rvalid_n  = 1'b1;
          rdata_n   = rd_ok ? regs[rd_sel] : '0;
          rresp_n   = rd_ok ? RESP_OKAY : RESP_SLVERR;
          r_state_n = R_DATA;
        end else begin
          arready_n = 1'b1;
        end
      end
      R_DATA: begin
        if (rready) begin
          rvalid_n  = 1'b0;
          arready_n = 1'b1;
          r_state_n = R_IDLE;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state      <= W_IDLE;
      r_state      <= R_IDLE;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      awready      <= 1'b0;
      wready       <= 1'b0;
      bvalid       <= 1'b0;
      bresp        <= '0;
      reg_wr_pulse <= '0;
      arready      <= 1'b0;
      rvalid       <= 1'b0;
      rdata        <= '0;
      rresp        <= '0;
    end else begin
      w_state      <= w_state_n;
      r_state      <= r_state_n;
      aw_held      <= aw_held_n;
      w_held       <= w_held_n;
      aw_addr_q    <= aw_addr_n;
      w_data_q     <= w_data_n;
      w_strb_q     <= w_strb_n;
      awready      <= awready_n;
      wready       <= wready_n;
      bvalid       <= bvalid_n;
      bresp        <= bresp_n;
      reg_wr_pulse <= pulse_n;
      arready      <= arready_n;
      rvalid       <= rvalid_n;
      rdata        <= rdata_n;
      rresp        <= rresp_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (w_strb_n[k]) regs[wr_sel][k*8 +: 8] <= w_data_n[k*8 +: 8];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_axil_csr_regfile.sv
// Self-checking bench for axil_csr_regfile: directed scenarios plus a randomised write/read scoreboard.
// Build with AXIL_CSR_STRB_EN defined to also exercise byte-strobe writes.
module tb_axil_csr_regfile;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;

  logic            clk;
  logic            rst_n;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic [AW-1:0]   awaddr, araddr;
  logic [DW-1:0]   wdata, rdata;
  logic [3:0]      wstrb;
  logic [1:0]      bresp, rresp;
  logic            arvalid, arready, rvalid, rready;
  logic [NR*DW-1:0] reg_q;
  logic [NR-1:0]   reg_wr_pulse;

  logic [DW-1:0]   model [NR];
  logic [DW-1:0]   exp_q[$];
  logic [1:0]      exp_resp_q[$];
  logic [NR-1:0]   exp_pulse_q[$];
  int              errors;
  int              checks;

  axil_csr_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
`ifdef AXIL_CSR_STRB_EN
    .wstrb(wstrb),
`endif
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- model ----------------
  task automatic model_clear();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  task automatic model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb);
    int idx;
    logic [3:0] eff;
    idx = int'(addr[AW-1:2]);
`ifdef AXIL_CSR_STRB_EN
    eff = strb;
`else
    eff = 4'hF;
`endif
    if (addr[AW-1:2] < NR) begin
      for (int k = 0; k < 4; k++) if (eff[k]) model[idx][k*8 +: 8] = data[k*8 +: 8];
    end
  endtask

  function automatic logic [NR*DW-1:0] model_vec();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = model[i];
    return v;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [AW-1:0] addr);
    return (addr[AW-1:2] < NR) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [NR-1:0] exp_pulse(input logic [AW-1:0] addr);
    logic [NR-1:0] p;
    p = '0;
    if (addr[AW-1:2] < NR) p[addr[5:2]] = 1'b1;
    return p;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output logic [NR-1:0] pulse);
    resp  = 2'bxx;
    pulse = 'x;
    fork
      begin
        repeat (aw_dly) tick();
        awaddr = addr; awvalid = 1'b1;
        for (int n = 0; n < 50 && !awready; n++) tick();
        checks++;
        if (!awready) begin errors++; $display("FAIL aw_timeout awready=%b required=1", awready); end
        tick();
        awvalid = 1'b0;
      end
      begin
        repeat (w_dly) tick();
        wdata = data; wstrb = strb; wvalid = 1'b1;
        for (int n = 0; n < 50 && !wready; n++) tick();
        checks++;
        if (!wready) begin errors++; $display("FAIL w_timeout wready=%b required=1", wready); end
        tick();
        wvalid = 1'b0;
      end
    join
    bready = 1'b1;
    for (int n = 0; n < 50 && !bvalid; n++) tick();
    checks++;
    if (!bvalid) begin errors++; $display("FAIL b_timeout bvalid=%b required=1", bvalid); end
    resp  = bresp;
    pulse = reg_wr_pulse;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data, output logic [1:0] resp);
    araddr = addr; arvalid = 1'b1;
    for (int n = 0; n < 50 && !arready; n++) tick();
    checks++;
    if (!arready) begin errors++; $display("FAIL ar_timeout arready=%b required=1", arready); end
    tick();
    arvalid = 1'b0;
    rready = 1'b1;
    for (int n = 0; n < 50 && !rvalid; n++) tick();
    checks++;
    if (!rvalid) begin errors++; $display("FAIL r_timeout rvalid=%b required=1", rvalid); end
    data = rdata;
    resp = rresp;
    tick();
    rready = 1'b0;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_hs got=%b required=00000", {awready, wready, arready, bvalid, rvalid});
    end
    checks++;
    if (reg_q !== '0 || reg_wr_pulse !== '0) begin
      errors++; $display("FAIL reset_regs reg_q=%h pulse=%h required=0", reg_q, reg_wr_pulse);
    end
    checks++;
    if ({bresp, rresp, rdata} !== '0) begin
      errors++; $display("FAIL reset_resp bresp=%b rresp=%b rdata=%h required=0", bresp, rresp, rdata);
    end
    rst_n = 1'b1;
    model_clear();
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      errors++; $display("FAIL ready_before_edge got=%b required=000", {awready, wready, arready});
    end
    tick();
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL ready_after_release got=%b required=111", {awready, wready, arready});
    end
  endtask

  task automatic test_write_same_cycle();
    logic [DW-1:0] d;
    logic [1:0] r;
    awaddr = 32'h8; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    exp_resp_q.push_back(2'b00);
    exp_pulse_q.push_back(16'h0004);
    model_write(32'h8, 32'hDEADBEEF, 4'hF);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || bresp !== exp_resp_q.pop_front()) begin
      errors++; $display("FAIL same_cycle_b bvalid=%b bresp=%b required=1/00", bvalid, bresp);
    end
    checks++;
    if (reg_q[2*DW +: DW] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL same_cycle_reg got=%h required=deadbeef", reg_q[2*DW +: DW]);
    end
    checks++;
    if (reg_wr_pulse !== exp_pulse_q.pop_front() || awready !== 1'b0 || wready !== 1'b0) begin
      errors++; $display("FAIL same_cycle_pulse pulse=%h aw/w ready=%b%b required=0004/00", reg_wr_pulse, awready, wready);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || reg_wr_pulse !== '0 || {awready, wready} !== 2'b11) begin
      errors++; $display("FAIL same_cycle_done bvalid=%b pulse=%h ready=%b%b required=0/0000/11", bvalid, reg_wr_pulse, awready, wready);
    end
    exp_q.push_back(model[2]);
    exp_resp_q.push_back(2'b00);
    axi_read(32'h8, d, r);
    checks++;
    if (d !== exp_q.pop_front() || r !== exp_resp_q.pop_front()) begin
      errors++; $display("FAIL read_reg2 rdata=%h rresp=%b required=deadbeef/00", d, r);
    end
  endtask

  task automatic test_w_before_aw();
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    checks++;
    if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
      errors++; $display("FAIL w_first_hold wready=%b awready=%b bvalid=%b required=0/1/0", wready, awready, bvalid);
    end
    tick(); tick();
    checks++;
    if (bvalid !== 1'b0 || reg_q[1*DW +: DW] !== model[1] || wready !== 1'b0) begin
      errors++; $display("FAIL w_first_early bvalid=%b reg1=%h wready=%b required=0/%h/0", bvalid, reg_q[1*DW +: DW], wready, model[1]);
    end
    awaddr = 32'h4; awvalid = 1'b1;
    model_write(32'h4, 32'h12345678, 4'hF);
    tick();
    awvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || reg_q[1*DW +: DW] !== model[1] || reg_wr_pulse !== 16'h0002) begin
      errors++; $display("FAIL w_first_commit bvalid=%b bresp=%b reg1=%h pulse=%h required=1/00/%h/0002", bvalid, bresp, reg_q[1*DW +: DW], reg_wr_pulse, model[1]);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic test_decode_error();
    logic [AW-1:0] waddr [3];
    logic [AW-1:0] raddr [4];
    logic [1:0] r;
    logic [NR-1:0] p;
    logic [DW-1:0] d;
    waddr = '{32'h40, 32'h3C, 32'h7};
    raddr = '{32'h40, 32'h3C, 32'h5, 32'hFFFFFFFC};
    for (int i = 0; i < 3; i++) begin
      exp_resp_q.push_back(exp_resp(waddr[i]));
      exp_pulse_q.push_back(exp_pulse(waddr[i]));
      model_write(waddr[i], 32'hCAFE0000 | i, 4'hF);
      axi_write(waddr[i], 32'hCAFE0000 | i, 4'hF, 0, 0, r, p);
      checks++;
      if (r !== exp_resp_q.pop_front() || p !== exp_pulse_q.pop_front()) begin
        errors++; $display("FAIL decode_write addr=%h bresp=%b pulse=%h required=%b/%h", waddr[i], r, p, exp_resp(waddr[i]), exp_pulse(waddr[i]));
      end
    end
    checks++;
    if (reg_q !== model_vec()) begin
      errors++; $display("FAIL decode_regs got=%h required=%h", reg_q, model_vec());
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back((raddr[i][AW-1:2] < NR) ? model[raddr[i][5:2]] : 32'h0);
      exp_resp_q.push_back(exp_resp(raddr[i]));
      axi_read(raddr[i], d, r);
      checks++;
      if (d !== exp_q.pop_front() || r !== exp_resp_q.pop_front()) begin
        errors++; $display("FAIL decode_read addr=%h rdata=%h rresp=%b required=%b", raddr[i], d, r, exp_resp(raddr[i]));
      end
    end
  endtask

  task automatic test_bready_stall();
    awaddr = 32'hC; wdata = 32'hA5A50003; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    model_write(32'hC, 32'hA5A50003, 4'hF);
    tick();
    wvalid = 1'b0;
    awaddr = 32'h10; wdata = 32'h5A5A0004;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
        errors++; $display("FAIL stall_cycle%0d bvalid=%b bresp=%b awready=%b wready=%b required=1/00/0/0", i, bvalid, bresp, awready, wready);
      end
      tick();
    end
    checks++;
    if (reg_q[4*DW +: DW] !== model[4]) begin
      errors++; $display("FAIL stall_second_early reg4=%h required=%h", reg_q[4*DW +: DW], model[4]);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      errors++; $display("FAIL stall_release bvalid=%b awready=%b wready=%b required=0/1/1", bvalid, awready, wready);
    end
    wvalid = 1'b1;
    model_write(32'h10, 32'h5A5A0004, 4'hF);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || reg_q[4*DW +: DW] !== model[4] || reg_q[3*DW +: DW] !== model[3]) begin
      errors++; $display("FAIL stall_second_commit bvalid=%b reg4=%h reg3=%h required=1/%h/%h", bvalid, reg_q[4*DW +: DW], reg_q[3*DW +: DW], model[4], model[3]);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic test_collision();
    logic [1:0] r;
    logic [NR-1:0] p;
    model_write(32'hC, 32'h11111111, 4'hF);
    axi_write(32'hC, 32'h11111111, 4'hF, 1, 0, r, p);
    exp_q.push_back(model[3]);
    model_write(32'hC, 32'h22222222, 4'hF);
    awaddr = 32'hC; wdata = 32'h22222222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'hC; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== exp_q.pop_front()) begin
      errors++; $display("FAIL collision_read rvalid=%b rdata=%h required=1/11111111", rvalid, rdata);
    end
    checks++;
    if (reg_q[3*DW +: DW] !== model[3] || bvalid !== 1'b1) begin
      errors++; $display("FAIL collision_write reg3=%h bvalid=%b required=%h/1", reg_q[3*DW +: DW], bvalid, model[3]);
    end
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int pulses, beats;
    pulses = 0; beats = 0;
    awaddr = 32'h14; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    model_write(32'h14, 32'h77, 4'hF);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (reg_wr_pulse[5]) pulses++;
      if (bvalid) beats++;
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    checks++;
    if (pulses !== 5 || beats !== 5) begin
      errors++; $display("FAIL b2b_write pulses=%0d bvalid_cycles=%0d required=5/5", pulses, beats);
    end
    beats = 0;
    araddr = 32'h14; arvalid = 1'b1; rready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rvalid) begin
        beats++;
        checks++;
        if (rdata !== model[5]) begin errors++; $display("FAIL b2b_rdata got=%h required=%h", rdata, model[5]); end
      end
    end
    arvalid = 1'b0; rready = 1'b0;
    checks++;
    if (beats !== 5) begin
      errors++; $display("FAIL b2b_read rvalid_cycles=%0d required=5", beats);
    end
  endtask

`ifdef AXIL_CSR_STRB_EN
  task automatic test_strobe();
    logic [1:0] r;
    logic [NR-1:0] p;
    axi_write(32'h0, 32'hFFFFFFFF, 4'hF, 0, 0, r, p);
    model_write(32'h0, 32'hFFFFFFFF, 4'hF);
    axi_write(32'h0, 32'h00000000, 4'b0101, 0, 2, r, p);
    model_write(32'h0, 32'h00000000, 4'b0101);
    checks++;
    if (reg_q[0 +: DW] !== 32'hFF00FF00) begin
      errors++; $display("FAIL strobe_mask reg0=%h required=ff00ff00", reg_q[0 +: DW]);
    end
    axi_write(32'h0, 32'h12345678, 4'b0000, 0, 0, r, p);
    checks++;
    if (p !== 16'h0001 || r !== 2'b00 || reg_q[0 +: DW] !== 32'hFF00FF00) begin
      errors++; $display("FAIL strobe_zero pulse=%h bresp=%b reg0=%h required=0001/00/ff00ff00", p, r, reg_q[0 +: DW]);
    end
  endtask
`endif

  task automatic test_random();
    logic [AW-1:0] a;
    logic [DW-1:0] d, dv;
    logic [3:0] s;
    logic [1:0] r;
    logic [NR-1:0] p;
    for (int i = 0; i < 24; i++) begin
      a = {$urandom_range(0, 19), 2'($urandom_range(0, 3))};
      dv = $urandom;
      s = 4'($urandom_range(0, 15));
      exp_resp_q.push_back(exp_resp(a));
      exp_pulse_q.push_back(exp_pulse(a));
      model_write(a, dv, s);
      axi_write(a, dv, s, $urandom_range(0, 3), $urandom_range(0, 3), r, p);
      checks++;
      if (r !== exp_resp_q.pop_front() || p !== exp_pulse_q.pop_front()) begin
        errors++; $display("FAIL rand_write addr=%h bresp=%b pulse=%h required=%b/%h", a, r, p, exp_resp(a), exp_pulse(a));
      end
      a = {$urandom_range(0, 19), 2'b00};
      exp_q.push_back((a[AW-1:2] < NR) ? model[a[5:2]] : 32'h0);
      exp_resp_q.push_back(exp_resp(a));
      axi_read(a, d, r);
      checks++;
      if (d !== exp_q.pop_front() || r !== exp_resp_q.pop_front()) begin
        errors++; $display("FAIL rand_read addr=%h rdata=%h rresp=%b required_resp=%b", a, d, r, exp_resp(a));
      end
    end
    checks++;
    if (reg_q !== model_vec()) begin
      errors++; $display("FAIL rand_regs got=%h required=%h", reg_q, model_vec());
    end
  endtask

  task automatic test_reset_mid_read();
    araddr = 32'h8; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || reg_q === '0) begin
      errors++; $display("FAIL midrd_pending rvalid=%b reg_q_nonzero=%b required=1/1", rvalid, reg_q !== '0);
    end
    rst_n = 1'b0;
    #1;
    model_clear();
    checks++;
    if (rvalid !== 1'b0 || reg_q !== model_vec() || arready !== 1'b0) begin
      errors++; $display("FAIL midrd_async rvalid=%b reg_q=%h arready=%b required=0/0/0", rvalid, reg_q, arready);
    end
    tick();
    rst_n = 1'b1;
    checks++;
    if (arready !== 1'b0) begin errors++; $display("FAIL midrd_before_edge arready=%b required=0", arready); end
    tick();
    checks++;
    if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100) begin
      errors++; $display("FAIL midrd_release got=%b required=11100", {arready, awready, wready, rvalid, bvalid});
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    errors = 0; checks = 0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = 4'hF;
    model_clear();
    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_decode_error();
    test_bready_stall();
    test_collision();
    test_back_to_back();
`ifdef AXIL_CSR_STRB_EN
    test_strobe();
`endif
    test_random();
    test_reset_mid_read();
    checks++;
    if (exp_q.size() + exp_resp_q.size() + exp_pulse_q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size() + exp_resp_q.size() + exp_pulse_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axil_csr_regfile.md
# axil_csr_regfile

Parametrised AXI4-Lite slave register file that terminates an AXI-Lite bus on the slave side and exposes `NUM_REGS` read/write control registers to the DMA datapath. It generalises the plain AXI-Lite channel bundle into an active endpoint with:

- independent AW/W acceptance;
- address decode with error responses;
- optional byte-strobe writes;
- a per-register write strobe to hardware.

## Interface

Parameters:
- `ADDR_WIDTH`, 32, AXI-Lite address width.
- `DATA_WIDTH`, 32, data width; must be 32 or 64.
- `NUM_REGS`, 16, number of registers; ≥1.
- `ADDR_LSB`, derived as `$clog2(DATA_WIDTH/8)`, byte-offset bits ignored by decode.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `awvalid`/`awready`  in/out  1  write address handshake.
- `awaddr`  in  `ADDR_WIDTH`  write byte address.
- `wvalid`/`wready`  in/out  1  write data handshake.
- `wdata`  in  `DATA_WIDTH`  write data.
- `wstrb`  in  `DATA_WIDTH/8`  byte strobes; present only with `AXIL_CSR_STRB_EN`.
- `bvalid`/`bready`  out/in  1  write response handshake.
- `bresp`  out  2  write response.
- `arvalid`/`arready`  in/out  1  read address handshake.
- `araddr`  in  `ADDR_WIDTH`  read byte address.
- `rvalid`/`rready`  out/in  1  read data handshake.
- `rdata`  out  `DATA_WIDTH`  read data.
- `rresp`  out  2  read response.
- `reg_q`  out  `NUM_REGS*DATA_WIDTH`  register contents; register i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `reg_wr_pulse`  out  `NUM_REGS`  one-cycle pulse on the cycle register i's new value first appears on `reg_q`.

## Operation

Reset: all outputs are registered and read 0 while `rst_n` is low, including `reg_q` and all readies. Readies rise on the first clock edge after `rst_n` deasserts. Asserting reset mid-transaction aborts it; no response is issued.

Decode:
- Word index = `addr[ADDR_WIDTH-1:ADDR_LSB]`; byte-offset bits are ignored.
- Index < `NUM_REGS`: OKAY (2'b00).
- Index ≥ `NUM_REGS`: SLVERR (2'b10). Writes have no effect; `rdata` is 0.

Write path, states `W_IDLE` → `W_RESP`:
- In `W_IDLE`, AW and W are captured independently. `awready` is high until AW is held; `wready` is high until W is held.
- Either channel may handshake first or both may handshake in the same cycle.
- The commit edge is the edge where the second of the pair is held:
  - the register is written;
  - `bvalid` and `bresp` rise;
  - `reg_wr_pulse[i]` rises, for OKAY only.
  - The FSM enters `W_RESP`.
- In `W_RESP`: `awready`, `wready` and `bvalid` hold until `bvalid && bready`. `bresp` also holds.
- On that handshake edge the FSM returns to `W_IDLE`; the readies rise on the same edge.
- `reg_wr_pulse` is exactly one cycle wide.

Read path, states `R_IDLE` → `R_DATA`:
- `arready` = 1 in `R_IDLE`.
- On `arvalid && arready`, `rdata`/`rresp` are registered from the current `reg_q` and `rvalid` rises. The FSM enters `R_DATA`.
- `rdata`, `rresp` and `rvalid` are stable until `rvalid && rready`, then the FSM returns to `R_IDLE`.

Collisions:
- Read and write paths run concurrently.
- An AR handshake on the same edge as a write commit to the same register returns the pre-write value.

## Timing

- Write latency: `bvalid` is high the cycle after the completing handshake. `reg_q` updates in that same cycle.
- Read latency: `rvalid` is high the cycle after the AR handshake.
- Back-to-back throughput is one write per 2 cycles when `bready` is tied high; reads behave the same with `rready` tied high.
- There are no combinational paths from any input to any output.

## Configuration

`AXIL_CSR_STRB_EN`:
- Defined: the `wstrb` port exists. Only bytes with `wstrb[k]` = 1 are updated. `reg_wr_pulse` fires for any OKAY write, including `wstrb` = 0.
- Undefined: no `wstrb` port; every write updates the full word.

## Test plan

- Reset, then write reg 2 = 0xDEADBEEF with AW and W in the same cycle → `bvalid` next cycle with OKAY; `reg_q` reg 2 = 0xDEADBEEF; `reg_wr_pulse` = 0x0004 for one cycle. Read addr 0x8 → `rdata` 0xDEADBEEF, `rresp` 0.
- W presented 3 cycles before AW (addr 0x4, data 0x12345678) → `wready` drops after the W handshake; commit only after the AW handshake; reg 1 = 0x12345678.
- Write/read addr 0x40 with `NUM_REGS` = 16 → `bresp` 2'b10 with no register change and no pulse; `rresp` 2'b10 with `rdata` 0.
- Hold `bready` low 5 cycles → `bvalid`/`bresp` stable; `awready`/`wready` stay low; a second AW waits until the B handshake.
- With `AXIL_CSR_STRB_EN`: reg 0 = 0xFFFFFFFF, then write 0x00000000 with `wstrb` 4'b0101 → reg 0 = 0xFF00FF00.
- Assert `rst_n` low while `rvalid` is pending → `rvalid` = 0 and all `reg_q` = 0 immediately; `arready` = 1 the first edge after release.
